// File: rtl/mips_mc_control_if.sv
// Control bundle between the multicycle MIPS main FSM and its datapath.
// The controller takes the master view; the datapath (or a bench) takes the slave view.
interface mips_mc_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
           illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
           illegal_op, state
  );
endinterface

// File: rtl/mips_mc_control.sv
// Main control FSM of the 32-bit multicycle MIPS core: decodes the opcode and
// sequences fetch/decode/execute/memory/write-back, stretching memory states on mem_ready.
module mips_mc_control (
  input  logic                clk,
  input  logic                rst_n,
  mips_mc_control_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_r;
  state_t     next_state_s;

  logic       iord_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_dst_s;
  logic       mem_to_reg_s;
  logic       reg_write_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic [1:0] pc_src_s;
  logic       pc_en_s;
  logic       illegal_op_s;

  // State register; reset is the only abort path and always lands in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-state control decode; anything not driven in a state stays 0.
  always_comb begin
    next_state_s = S_FETCH;
    iord_s       = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    pc_src_s     = 2'b00;
    pc_en_s      = 1'b0;
    illegal_op_s = 1'b0;

    case (state_r)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
        ir_write_s  = bus.mem_ready;
        pc_en_s     = bus.mem_ready;
        if (bus.mem_ready) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target is computed speculatively here so BEQEX only has to compare.
        alu_src_b_s = 2'b11;
        case (bus.opcode)
          OP_LW:    next_state_s = S_MEMADR;
          OP_SW:    next_state_s = S_MEMADR;
          OP_RTYPE: next_state_s = S_RTYPEEX;
          OP_BEQ:   next_state_s = S_BEQEX;
          OP_ADDI:  next_state_s = S_ADDIEX;
          OP_J:     next_state_s = S_JEX;
          default: begin
            illegal_op_s = 1'b1;
            next_state_s = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        if (bus.opcode == OP_SW) begin
          next_state_s = S_MEMWR;
        end else begin
          next_state_s = S_MEMRD;
        end
      end
      S_MEMRD: begin
        iord_s     = 1'b1;
        mem_read_s = 1'b1;
        if (bus.mem_ready) begin
          next_state_s = S_MEMWB;
        end else begin
          next_state_s = S_MEMRD;
        end
      end
      S_MEMWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWR: begin
        iord_s      = 1'b1;
        mem_write_s = 1'b1;
        if (bus.mem_ready) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_RTYPEEX: begin
        alu_src_a_s  = 1'b1;
        alu_op_s     = 2'b10;
        next_state_s = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        reg_write_s  = 1'b1;
        reg_dst_s    = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BEQEX: begin
        alu_src_a_s  = 1'b1;
        alu_op_s     = 2'b01;
        pc_src_s     = 2'b01;
        pc_en_s      = bus.zero;
        next_state_s = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        next_state_s = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JEX: begin
        pc_src_s     = 2'b10;
        pc_en_s      = 1'b1;
        next_state_s = S_FETCH;
      end
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  // Enables and requests are held off while reset is asserted; selects pass through.
  assign bus.ir_write   = rst_n & ir_write_s;
  assign bus.pc_en      = rst_n & pc_en_s;
  assign bus.reg_write  = rst_n & reg_write_s;
  assign bus.mem_write  = rst_n & mem_write_s;
  assign bus.mem_read   = rst_n & mem_read_s;
  assign bus.illegal_op = rst_n & illegal_op_s;

  assign bus.iord       = iord_s;
  assign bus.reg_dst    = reg_dst_s;
  assign bus.mem_to_reg = mem_to_reg_s;
  assign bus.alu_src_a  = alu_src_a_s;
  assign bus.alu_src_b  = alu_src_b_s;
  assign bus.alu_op     = alu_op_s;
  assign bus.pc_src     = pc_src_s;
  assign bus.state      = state_r;

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: directed per-cycle vectors push expected
// state and control word; a negedge monitor pops and compares.
module tb_mips_mc_control;

  logic clk;
  logic rst_n;

  mips_mc_control_if bus ();

  mips_mc_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  // Control word: {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
  //                alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0], pc_en, illegal_op}
  localparam logic [15:0] C_RST     = 16'h0040;
  localparam logic [15:0] C_FETCH   = 16'h5042;
  localparam logic [15:0] C_FWAIT   = 16'h4040;
  localparam logic [15:0] C_DECODE  = 16'h00C0;
  localparam logic [15:0] C_ILLEGAL = 16'h00C1;
  localparam logic [15:0] C_ADREX   = 16'h0180;
  localparam logic [15:0] C_MEMRD   = 16'hC000;
  localparam logic [15:0] C_MEMWB   = 16'h0600;
  localparam logic [15:0] C_MEMWR   = 16'hA000;
  localparam logic [15:0] C_RTEX    = 16'h0120;
  localparam logic [15:0] C_RTWB    = 16'h0A00;
  localparam logic [15:0] C_BEQ_T   = 16'h0116;
  localparam logic [15:0] C_BEQ_N   = 16'h0114;
  localparam logic [15:0] C_ADIWB   = 16'h0200;
  localparam logic [15:0] C_JEX     = 16'h000A;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctrl;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  event  async_ev;
  int    checks = 0;
  int    errors = 0;

  logic [15:0] act_ctrl;
  assign act_ctrl = {bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
                     bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                     bus.alu_op, bus.pc_src, bus.pc_en, bus.illegal_op};

  // Monitor: compare the oldest expectation whenever the DUT is sampled.
  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk or async_ev);
      if (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (bus.state !== e.st) begin
          errors++;
          $display("FAIL %s state: got %0d expected %0d", nm, bus.state, e.st);
        end
        checks++;
        if (act_ctrl !== e.ctrl) begin
          errors++;
          $display("FAIL %s ctrl: got %h expected %h", nm, act_ctrl, e.ctrl);
        end
      end
    end
  end

  task automatic push_exp(input logic [3:0] st, input logic [15:0] ctrl, input string nm);
    exp_t e;
    e.st   = st;
    e.ctrl = ctrl;
    sb_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // One clock cycle: drive inputs just after the rising edge, record what this cycle must show.
  task automatic step(input logic rst, input logic [5:0] opc, input logic z, input logic rdy,
                      input logic [3:0] st, input logic [15:0] ctrl, input string nm);
    @(posedge clk);
    #1;
    rst_n         = rst;
    bus.opcode    = opc;
    bus.zero      = z;
    bus.mem_ready = rdy;
    push_exp(st, ctrl, nm);
  endtask

  // Assert reset between clock edges; state must clear without waiting for an edge.
  task automatic async_reset(input string nm);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    push_exp(4'd0, C_RST, nm);
    -> async_ev;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    rst_n         = 1'b0;
    bus.opcode    = LW;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    step(1'b0, LW, 1'b0, 1'b1, 4'd0, C_RST, "reset_hold0");
    step(1'b0, LW, 1'b0, 1'b1, 4'd0, C_RST, "reset_hold1");

    // lw, no wait states: 0,1,2,3,4
    step(1'b1, LW, 1'b0, 1'b1, 4'd0, C_FETCH,  "lw_fetch");
    step(1'b1, LW, 1'b0, 1'b1, 4'd1, C_DECODE, "lw_decode");
    step(1'b1, LW, 1'b0, 1'b1, 4'd2, C_ADREX,  "lw_memadr");
    step(1'b1, LW, 1'b0, 1'b1, 4'd3, C_MEMRD,  "lw_memrd");
    step(1'b1, LW, 1'b0, 1'b1, 4'd4, C_MEMWB,  "lw_memwb");

    // sw with 3 fetch waits and 2 write waits
    for (int i = 0; i < 3; i++)
      step(1'b1, SW, 1'b0, 1'b0, 4'd0, C_FWAIT, "sw_fetch_wait");
    step(1'b1, SW, 1'b0, 1'b1, 4'd0, C_FETCH,  "sw_fetch");
    step(1'b1, SW, 1'b0, 1'b1, 4'd1, C_DECODE, "sw_decode");
    step(1'b1, SW, 1'b0, 1'b1, 4'd2, C_ADREX,  "sw_memadr");
    for (int i = 0; i < 2; i++)
      step(1'b1, SW, 1'b0, 1'b0, 4'd5, C_MEMWR, "sw_memwr_wait");
    step(1'b1, SW, 1'b0, 1'b1, 4'd5, C_MEMWR,  "sw_memwr");

    // lw with a stretched read
    step(1'b1, LW, 1'b0, 1'b1, 4'd0, C_FETCH,  "lw2_fetch");
    step(1'b1, LW, 1'b0, 1'b1, 4'd1, C_DECODE, "lw2_decode");
    step(1'b1, LW, 1'b0, 1'b1, 4'd2, C_ADREX,  "lw2_memadr");
    step(1'b1, LW, 1'b0, 1'b0, 4'd3, C_MEMRD,  "lw2_memrd_wait");
    step(1'b1, LW, 1'b0, 1'b1, 4'd3, C_MEMRD,  "lw2_memrd");
    step(1'b1, LW, 1'b0, 1'b1, 4'd4, C_MEMWB,  "lw2_memwb");

    // R-type
    step(1'b1, RT, 1'b0, 1'b1, 4'd0, C_FETCH,  "rt_fetch");
    step(1'b1, RT, 1'b0, 1'b1, 4'd1, C_DECODE, "rt_decode");
    step(1'b1, RT, 1'b0, 1'b1, 4'd6, C_RTEX,   "rt_ex");
    step(1'b1, RT, 1'b0, 1'b1, 4'd7, C_RTWB,   "rt_wb");

    // beq taken, then not taken
    step(1'b1, BEQ, 1'b1, 1'b1, 4'd0, C_FETCH,  "beq1_fetch");
    step(1'b1, BEQ, 1'b1, 1'b1, 4'd1, C_DECODE, "beq1_decode");
    step(1'b1, BEQ, 1'b1, 1'b1, 4'd8, C_BEQ_T,  "beq1_ex");
    step(1'b1, BEQ, 1'b0, 1'b1, 4'd0, C_FETCH,  "beq0_fetch");
    step(1'b1, BEQ, 1'b0, 1'b1, 4'd1, C_DECODE, "beq0_decode");
    step(1'b1, BEQ, 1'b0, 1'b1, 4'd8, C_BEQ_N,  "beq0_ex");

    // addi; mem_ready low outside memory states must not stall
    step(1'b1, ADI, 1'b0, 1'b1, 4'd0,  C_FETCH,  "addi_fetch");
    step(1'b1, ADI, 1'b0, 1'b0, 4'd1,  C_DECODE, "addi_decode");
    step(1'b1, ADI, 1'b0, 1'b0, 4'd9,  C_ADREX,  "addi_ex");
    step(1'b1, ADI, 1'b0, 1'b0, 4'd10, C_ADIWB,  "addi_wb");

    // illegal opcode, then j
    step(1'b1, BAD, 1'b0, 1'b1, 4'd0,  C_FETCH,   "ill_fetch");
    step(1'b1, BAD, 1'b0, 1'b1, 4'd1,  C_ILLEGAL, "ill_decode");
    step(1'b1, JMP, 1'b0, 1'b1, 4'd0,  C_FETCH,   "j_fetch");
    step(1'b1, JMP, 1'b0, 1'b1, 4'd1,  C_DECODE,  "j_decode");
    step(1'b1, JMP, 1'b0, 1'b1, 4'd11, C_JEX,     "j_ex");

    // reset asserted during RTYPEEX: no write-back, restart at FETCH
    step(1'b1, RT, 1'b0, 1'b1, 4'd0, C_FETCH,  "rst_rt_fetch");
    step(1'b1, RT, 1'b0, 1'b1, 4'd1, C_DECODE, "rst_rt_decode");
    step(1'b1, RT, 1'b0, 1'b1, 4'd6, C_RTEX,   "rst_rt_ex");
    async_reset("rst_async");
    step(1'b0, RT, 1'b0, 1'b1, 4'd0, C_RST,    "rst_rt_held");
    step(1'b1, RT, 1'b0, 1'b1, 4'd0, C_FETCH,  "rst_rt_refetch");
    step(1'b1, RT, 1'b0, 1'b1, 4'd1, C_DECODE, "rst_rt_redecode");

    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
